// File: rtl/threadbrain_pkg.sv
// Shared definitions for the threadbrain core: opcodes, NOP word,
// fetch state encoding and the default instruction address width.
package threadbrain_pkg;

   localparam int unsigned ADDR_W_DEF = 12;

   localparam logic [3:0] OP_PLUS  = 4'h1;
   localparam logic [3:0] OP_MINUS = 4'h2;
   localparam logic [3:0] OP_INC   = 4'h3;
   localparam logic [3:0] OP_DEC   = 4'h4;
   localparam logic [3:0] OP_BRZ   = 4'h5;
   localparam logic [3:0] OP_BR    = 4'h6;
   localparam logic [3:0] OP_SYNC  = 4'h8;
   localparam logic [3:0] OP_PRINT = 4'h9;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [15:0] NOP = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_perf.sv
// Saturating pair of fetch-stage performance counters: delivered
// instructions and bubble cycles while the stage is running.
module fetch_perf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run_i,
   input  logic        nop_i,
   input  logic        stall_i,
   output logic [31:0] ins_cnt_o,
   output logic [31:0] bub_cnt_o
);

   logic [31:0] ins_q, ins_d;
   logic [31:0] bub_q, bub_d;

   // Classify the current RUN cycle and bump the matching counter, saturating at all-ones.
   always_comb begin
      ins_d = ins_q;
      bub_d = bub_q;
      if (run_i) begin
         if (!nop_i && !stall_i) begin
            if (ins_q != '1) ins_d = ins_q + 32'd1;
         end else begin
            if (bub_q != '1) bub_d = bub_q + 32'd1;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ins_q <= '0;
         bub_q <= '0;
      end else begin
         ins_q <= ins_d;
         bub_q <= bub_d;
      end
   end

   assign ins_cnt_o = ins_q;
   assign bub_cnt_o = bub_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the pc, drives the synchronous ROM and
// hands one instruction per cycle to the ALU, handling redirect, SYNC
// replay, fork start and HALT.
// Optional macro FETCH_PERF_EN adds perf_ins / perf_bubbles counters.
module fetch_stage
   import threadbrain_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter bit          BOOT_RUN = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_rd,
   input  logic [15:0]       imem_data,
   input  logic              branch_en,
   input  logic [15:0]       branch_val,
   input  logic              stall,
   input  logic              fork_en,
   input  logic [15:0]       fork_pc,
   output logic [15:0]       ins_out,
   output logic [ADDR_W-1:0] pc_out,
   output logic              running,
   output logic              halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_ins,
   output logic [31:0]       perf_bubbles
`endif
);

   localparam fetch_state_e RST_STATE = BOOT_RUN ? ST_RUN : ST_IDLE;

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] ra_q, ra_d;
   logic              fvalid_q, fvalid_d;
   logic [ADDR_W-1:0] faddr_q, faddr_d;
   logic [15:0]       replay_q, replay_d;
   logic [ADDR_W-1:0] rpc_q, rpc_d;

   logic [15:0]       ins_sel;
   logic [ADDR_W-1:0] addr_sel;
   logic              run;

   assign run       = (state_q == ST_RUN);
   assign imem_addr = pc_q;
   assign imem_rd   = run;
   assign running   = run;
   assign halted    = (state_q == ST_HALTED);

   // Select the word handed to the ALU this cycle and the address it came from.
   always_comb begin
      ins_sel  = NOP;
      addr_sel = '0;
      if (run && !branch_en) begin
         if (stall) begin
            ins_sel  = replay_q;
            addr_sel = rpc_q;
         end else if (fvalid_q) begin
            ins_sel  = imem_data;
            addr_sel = faddr_q;
         end
      end
   end

   assign ins_out = ins_sel;
   assign pc_out  = (ins_sel == NOP) ? '0 : addr_sel;

   // Next-state: fork > branch > stall > sequential fetch.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ra_d     = ra_q;
      fvalid_d = fvalid_q;
      faddr_d  = faddr_q;
      replay_d = replay_q;
      rpc_d    = rpc_q;
      case (state_q)
         ST_IDLE, ST_HALTED: begin
            replay_d = NOP;
            rpc_d    = '0;
            if (fork_en) begin
               state_d  = ST_RUN;
               pc_d     = fork_pc[ADDR_W-1:0];
               ra_d     = fork_pc[ADDR_W-1:0];
               fvalid_d = 1'b0;
            end
         end
         ST_RUN: begin
            if (branch_en) begin
               pc_d     = branch_val[ADDR_W-1:0];
               ra_d     = branch_val[ADDR_W-1:0];
               fvalid_d = 1'b0;
               replay_d = NOP;
               rpc_d    = '0;
            end else if (stall) begin
               // Refetch the oldest undelivered word; replay register holds.
               pc_d     = ra_q;
               fvalid_d = 1'b0;
            end else begin
               pc_d     = pc_q + ADDR_W'(1);
               ra_d     = pc_q;
               faddr_d  = pc_q;
               fvalid_d = 1'b1;
               replay_d = ins_sel;
               rpc_d    = pc_out;
               if (ins_sel[15:12] == OP_HALT) state_d = ST_HALTED;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset discards any in-flight ROM word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= RST_STATE;
         pc_q     <= '0;
         ra_q     <= '0;
         fvalid_q <= 1'b0;
         faddr_q  <= '0;
         replay_q <= NOP;
         rpc_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ra_q     <= ra_d;
         fvalid_q <= fvalid_d;
         faddr_q  <= faddr_d;
         replay_q <= replay_d;
         rpc_q    <= rpc_d;
      end
   end

`ifdef FETCH_PERF_EN
   fetch_perf u_perf (
      .clk       (clk),
      .rst_n     (rst_n),
      .run_i     (run),
      .nop_i     (ins_sel == NOP),
      .stall_i   (stall),
      .ins_cnt_o (perf_ins),
      .bub_cnt_o (perf_bubbles)
   );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: boot instance (BOOT_RUN=1) plus a fork-started
// instance driven by a directed vector table, hand sequences for reset
// corner cases, and random traffic against a delivery-stream model.
module tb_fetch_stage;
   import threadbrain_pkg::*;

   localparam int unsigned AW = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic [15:0] rom [4096];

   // main instance (BOOT_RUN = 0)
   logic [AW-1:0] m_addr, m_pc;
   logic          m_rd, m_run, m_halt;
   logic [15:0]   m_data, m_ins;
   logic          m_br, m_st, m_fe;
   logic [15:0]   m_bv, m_fp;

   // boot instance (BOOT_RUN = 1)
   logic [AW-1:0] b_addr, b_pc;
   logic          b_rd, b_run, b_halt;
   logic [15:0]   b_data, b_ins;

`ifdef FETCH_PERF_EN
   logic [31:0] m_pins, m_pbub, b_pins, b_pbub;
`endif

   fetch_stage #(.ADDR_W(AW), .BOOT_RUN(1'b0)) u_main (
      .clk(clk), .rst_n(rst_n), .imem_addr(m_addr), .imem_rd(m_rd), .imem_data(m_data),
      .branch_en(m_br), .branch_val(m_bv), .stall(m_st), .fork_en(m_fe), .fork_pc(m_fp),
      .ins_out(m_ins), .pc_out(m_pc), .running(m_run), .halted(m_halt)
`ifdef FETCH_PERF_EN
      , .perf_ins(m_pins), .perf_bubbles(m_pbub)
`endif
   );

   fetch_stage #(.ADDR_W(AW), .BOOT_RUN(1'b1)) u_boot (
      .clk(clk), .rst_n(rst_n), .imem_addr(b_addr), .imem_rd(b_rd), .imem_data(b_data),
      .branch_en(1'b0), .branch_val(16'h0000), .stall(1'b0), .fork_en(1'b0), .fork_pc(16'h0000),
      .ins_out(b_ins), .pc_out(b_pc), .running(b_run), .halted(b_halt)
`ifdef FETCH_PERF_EN
      , .perf_ins(b_pins), .perf_bubbles(b_pbub)
`endif
   );

   // synchronous ROMs
   always @(posedge clk) if (m_rd) m_data <= rom[m_addr];
   always @(posedge clk) if (b_rd) b_data <= rom[b_addr];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm,
                      input logic [15:0] ai, input logic [15:0] ei,
                      input logic [AW-1:0] ap, input logic [AW-1:0] ep,
                      input logic ar, input logic er,
                      input logic ah, input logic eh,
                      input logic ard);
      n_vec++;
      if (ai !== ei || ap !== ep || ar !== er || ah !== eh || ard !== er) begin
         n_err++;
         $display("FAIL %s: got ins=%h pc=%h run=%b halt=%b rd=%b, expected ins=%h pc=%h run=%b halt=%b rd=%b",
                  nm, ai, ap, ar, ah, ard, ei, ep, er, eh, er);
      end
   endtask

   task automatic chk_main(input string nm, input logic [15:0] ei, input logic [AW-1:0] ep,
                           input logic er, input logic eh);
      chk(nm, m_ins, ei, m_pc, ep, m_run, er, m_halt, eh, m_rd);
   endtask

   task automatic drive(input logic br, input logic [15:0] bv, input logic st,
                        input logic fe, input logic [15:0] fp);
      m_br = br; m_bv = bv; m_st = st; m_fe = fe; m_fp = fp;
   endtask

   // ---------------- delivery-stream reference model ----------------
   // Thinks in terms of "next address to deliver" and "bubbles still owed".
   bit          md_run, md_halted;
   int unsigned md_next, md_warm;
   logic [15:0] md_last;
   int unsigned md_lastpc;
   int unsigned md_cnt_ins, md_cnt_bub;

   task automatic model_reset();
      md_run = 0; md_halted = 0; md_next = 0; md_warm = 1;
      md_last = 16'h0; md_lastpc = 0; md_cnt_ins = 0; md_cnt_bub = 0;
   endtask

   task automatic model_step(input logic br, input logic [15:0] bv, input logic st,
                             input logic fe, input logic [15:0] fp,
                             output logic [15:0] e_ins, output logic [AW-1:0] e_pc,
                             output logic e_run, output logic e_halt);
      int unsigned epc;
      e_run = md_run; e_halt = md_halted;
      e_ins = 16'h0; epc = 0;
      if (!md_run) begin
         if (fe) begin
            md_run = 1; md_halted = 0; md_next = fp % 4096; md_warm = 1;
            md_last = 16'h0; md_lastpc = 0;
         end
      end else if (br) begin
         md_next = bv % 4096; md_warm = 1; md_last = 16'h0; md_lastpc = 0;
      end else if (st) begin
         e_ins = md_last; epc = md_lastpc; md_warm = 1;
      end else begin
         if (md_warm > 0) begin
            md_warm--;
         end else begin
            e_ins = rom[md_next];
            epc = (e_ins == 16'h0) ? 0 : md_next;
            md_next = (md_next + 1) % 4096;
         end
         md_last = e_ins; md_lastpc = epc;
         if (e_ins[15:12] == 4'hF) begin md_run = 0; md_halted = 1; end
      end
      if (e_run) begin
         if (e_ins != 16'h0 && !br && !st) md_cnt_ins++;
         else md_cnt_bub++;
      end
      e_pc = AW'(epc);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic br; logic [15:0] bv; logic st; logic fe; logic [15:0] fp;
      logic [15:0] ins; logic [AW-1:0] pc; logic run; logic halt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(input logic br, input logic [15:0] bv, input logic st,
                              input logic fe, input logic [15:0] fp,
                              input logic [15:0] ins, input logic [AW-1:0] pc,
                              input logic run, input logic halt);
      vec_t r;
      r.br = br; r.bv = bv; r.st = st; r.fe = fe; r.fp = fp;
      r.ins = ins; r.pc = pc; r.run = run; r.halt = halt;
      return r;
   endfunction

   logic [15:0] e_ins;
   logic [AW-1:0] e_pc;
   logic e_run, e_halt;

   initial begin
      rst_n = 1'b0;
      drive(0, 16'h0, 0, 0, 16'h0);
      for (int i = 0; i < 4096; i++) rom[i] = 16'h0;
      rom[0] = 16'h1001; rom[1] = 16'h1002; rom[2] = 16'h3000; rom[3] = 16'hF000;
      rom[5] = 16'h6010; rom[6] = 16'h1111; rom[7] = 16'h1112;
      rom[16'h10] = 16'h2000; rom[16'h11] = 16'h8201; rom[16'h12] = 16'h3003;
      rom[16'h13] = 16'h4004; rom[16'h14] = 16'hF000; rom[16'h40] = 16'h5ABC;
      rom[12'hFFE] = 16'h1FFE; rom[12'hFFF] = 16'h1FFF;

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_boot", b_ins, 16'h0, b_pc, '0, b_run, 1'b1, b_halt, 1'b0, b_rd);
      chk_main("reset_main", 16'h0, '0, 1'b0, 1'b0);

      // boot sequence: cycle 0 bubble, cycles 1-4 ROM[0..3], halted from cycle 5
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("boot_c0", b_ins, 16'h0, b_pc, '0, b_run, 1'b1, b_halt, 1'b0, b_rd);
      for (int c = 1; c <= 6; c++) begin
         logic [15:0] ei;
         @(negedge clk);
         ei = (c <= 4) ? rom[c-1] : 16'h0;
         chk($sformatf("boot_c%0d", c), b_ins, ei, b_pc, (c <= 4) ? AW'(c-1) : '0,
             b_run, (c <= 4), b_halt, (c >= 5), b_rd);
      end

      // fork / branch / SYNC replay / halt / refork / wrap
      tbl.push_back(v(0,16'h0,0,1,16'h0005, 16'h0000,12'h000,0,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h0000,12'h000,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h6010,12'h005,1,0));
      tbl.push_back(v(1,16'h0010,0,0,16'h0, 16'h0000,12'h000,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h0000,12'h000,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h2000,12'h010,1,0));
      tbl.push_back(v(0,16'h0,0,1,16'h0040, 16'h8201,12'h011,1,0));
      tbl.push_back(v(0,16'h0,1,0,16'h0,    16'h8201,12'h011,1,0));
      tbl.push_back(v(0,16'h0,1,0,16'h0,    16'h8201,12'h011,1,0));
      tbl.push_back(v(0,16'h0,1,0,16'h0,    16'h8201,12'h011,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h0000,12'h000,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h3003,12'h012,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h4004,12'h013,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'hF000,12'h014,1,0));
      tbl.push_back(v(1,16'h0000,1,0,16'h0, 16'h0000,12'h000,0,1));
      tbl.push_back(v(0,16'h0,0,1,16'h0040, 16'h0000,12'h000,0,1));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h0000,12'h000,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h5ABC,12'h040,1,0));
      tbl.push_back(v(1,16'hFFFE,1,0,16'h0, 16'h0000,12'h000,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h0000,12'h000,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h1FFE,12'hFFE,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h1FFF,12'hFFF,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h1001,12'h000,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h1002,12'h001,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h3000,12'h002,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'hF000,12'h003,1,0));
      tbl.push_back(v(0,16'h0,0,0,16'h0,    16'h0000,12'h000,0,1));
      foreach (tbl[i]) begin
         @(posedge clk); #1;
         drive(tbl[i].br, tbl[i].bv, tbl[i].st, tbl[i].fe, tbl[i].fp);
         @(negedge clk);
         chk_main($sformatf("tbl%0d", i), tbl[i].ins, tbl[i].pc, tbl[i].run, tbl[i].halt);
      end

      // reset in the middle of a stall
      @(posedge clk); #1 drive(0, 16'h0, 0, 1, 16'h0010);
      repeat (3) begin @(posedge clk); #1 drive(0, 16'h0, 0, 0, 16'h0); end
      @(negedge clk); chk_main("pre_stall", 16'h8201, 12'h011, 1'b1, 1'b0);
      @(posedge clk); #1 drive(0, 16'h0, 1, 0, 16'h0);
      @(negedge clk); chk_main("stall_a", 16'h8201, 12'h011, 1'b1, 1'b0);
      @(posedge clk); #1; #1 rst_n = 1'b0; #1;
      chk_main("rst_mid_stall", 16'h0, '0, 1'b0, 1'b0);
      @(posedge clk); #1 drive(0, 16'h0, 0, 0, 16'h0); rst_n = 1'b1;
      repeat (3) begin @(negedge clk); chk_main("post_rst_stall", 16'h0, '0, 1'b0, 1'b0); end

      // reset in the middle of a branch
      @(posedge clk); #1 drive(0, 16'h0, 0, 1, 16'h0005);
      @(posedge clk); #1 drive(0, 16'h0, 0, 0, 16'h0);
      @(posedge clk); #1;
      @(negedge clk); chk_main("pre_branch", 16'h6010, 12'h005, 1'b1, 1'b0);
      @(posedge clk); #1 drive(1, 16'h0010, 0, 0, 16'h0); #1;
      chk_main("branch_squash", 16'h0, '0, 1'b1, 1'b0);
      #1 rst_n = 1'b0; #1;
      chk_main("rst_mid_branch", 16'h0, '0, 1'b0, 1'b0);
      @(posedge clk); #1 drive(0, 16'h0, 0, 0, 16'h0); rst_n = 1'b1;
      repeat (3) begin @(negedge clk); chk_main("post_rst_branch", 16'h0, '0, 1'b0, 1'b0); end

      // randomized traffic against the model
      for (int r = 0; r < 4; r++) begin
         @(posedge clk); #1 rst_n = 1'b0; drive(0, 16'h0, 0, 0, 16'h0);
         for (int i = 0; i < 4096; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 15));
            if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h1;
            rom[i] = {op, 12'($urandom)};
         end
         #1 chk_main("rnd_reset", 16'h0, '0, 1'b0, 1'b0);
         @(posedge clk); #1 rst_n = 1'b1;
         model_reset();
         for (int c = 0; c < 700; c++) begin
            logic br, st, fe;
            logic [15:0] bv, fp;
            br = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 6) == 0);
            fe = ($urandom_range(0, 7) == 0);
            bv = 16'($urandom);
            fp = 16'($urandom);
            @(posedge clk); #1 drive(br, bv, st, fe, fp);
            @(negedge clk);
            model_step(br, bv, st, fe, fp, e_ins, e_pc, e_run, e_halt);
            chk_main("rnd", e_ins, e_pc, e_run, e_halt);
         end
`ifdef FETCH_PERF_EN
         n_vec++;
         @(posedge clk); #1 drive(0, 16'h0, 0, 0, 16'h0);
         if (m_pins !== md_cnt_ins || m_pbub !== md_cnt_bub + (md_run ? 1 : 0)) begin
            n_err++;
            $display("FAIL perf: got ins=%0d bub=%0d, expected ins=%0d bub=%0d",
                     m_pins, m_pbub, md_cnt_ins, md_cnt_bub + (md_run ? 1 : 0));
         end
`endif
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Per-core instruction fetch stage, directly upstream of the core ALU.
- Owns the program counter, drives the synchronous instruction ROM, and delivers one 16-bit instruction per cycle on ins_out, which feeds the ALU's ins_in.
- Consumes the ALU's branch_en/branch_val (redirect) and stall (SYNC replay), and is started by a fork context.

Parameters:
- ADDR_W, 12, instruction address width; branch targets are ins[11:0].
- BOOT_RUN, 0, 1 = leave reset in RUN at pc 0 (core 0); 0 = leave reset in IDLE awaiting fork.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- imem_addr  out  ADDR_W  ROM read address; data returns next cycle
- imem_rd  out  1  ROM read enable
- imem_data  in  16  ROM read data for the address issued last cycle
- branch_en  in  1  redirect request from ALU (combinational from ALU's registered ins)
- branch_val  in  16  redirect target; bits [ADDR_W-1:0] used
- stall  in  1  ALU SYNC not satisfied; replay last instruction
- fork_en  in  1  start request (fork_cxt valid bit)
- fork_pc  in  16  start pc (fork_cxt pc field); bits [ADDR_W-1:0] used
- ins_out  out  16  instruction to ALU; NOP (16'h0000) on bubbles
- pc_out  out  ADDR_W  address of the instruction on ins_out (0 when ins_out is NOP)
- running  out  1  state == RUN
- halted  out  1  state == HALTED

Behaviour:
- Registers: state {IDLE, RUN, HALTED}, pc (address issued this cycle), ra (oldest undelivered address), f_valid (imem_data valid), f_addr, replay_q (last ins_out).
- Reset: state = BOOT_RUN ? RUN : IDLE; pc = 0, ra = 0, f_valid = 0, replay_q = NOP. Outputs: ins_out = NOP, imem_rd = BOOT_RUN, pc_out = 0, running = BOOT_RUN, halted = 0.
- Reset mid-operation clears everything immediately. In-flight ROM data is discarded.
- Combinational outputs:
  - imem_addr = pc.
  - imem_rd = (state == RUN).
  - ins_out = stall ? replay_q : (f_valid && !branch_en && state == RUN) ? imem_data : NOP.
- Latency: 1 cycle from address issue to ins_out.
- Priority per cycle: fork_en > branch_en > stall > normal.
- fork_en:
  - Honoured only in IDLE or HALTED: pc <= fork_pc, f_valid <= 0, state <= RUN. First instruction appears 2 cycles later.
  - Ignored in RUN.
- branch_en (RUN):
  - Squash the word arriving this cycle (ins_out = NOP).
  - pc <= target, ra <= target, f_valid <= 0.
  - Penalty: exactly 1 bubble; target instruction appears 2 cycles after the branch is in the ALU.
  - Branch and stall asserted together: branch wins.
- stall (RUN):
  - ins_out = replay_q; replay_q held.
  - pc <= ra, ra held, f_valid <= 0 (refetch the undelivered word).
  - Released cycle: ins_out = NOP (1 bubble); next cycle delivers ra.
  - Stall sustained any number of cycles: same result, no instruction lost or duplicated.
- Normal (RUN):
  - pc <= pc + 1, wrapping mod 2^ADDR_W (4095 -> 0).
  - ra <= pc, f_addr <= pc, f_valid <= 1, replay_q <= ins_out.
- HALT (opcode 4'hF) delivered on ins_out:
  - Passed to the ALU once; state <= HALTED.
  - Afterwards ins_out = NOP, imem_rd = 0.
- IDLE/HALTED: ins_out = NOP, pc frozen; branch_en and stall ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: extra outputs perf_ins[31:0] and perf_bubbles[31:0].
  - perf_ins counts cycles in RUN with non-NOP ins_out and no stall.
  - perf_bubbles counts cycles in RUN with NOP ins_out or stall.
  - Both reset to 0 by rst_n, saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- threadbrain_pkg holds:
  - opcode constants PLUS=4'h1, MINUS=4'h2, INC=4'h3, DEC=4'h4, BRZ=4'h5, BR=4'h6, SYNC=4'h8, PRINT=4'h9, HALT=4'hF;
  - NOP = 16'h0000;
  - fetch state enum;
  - default ADDR_W.
- One sub-module, fetch_perf (the saturating counter pair), instantiated only under FETCH_PERF_EN.

Test Plan:
- BOOT_RUN=1, ROM[0..3] = 1001,1002,3000,F000 -> ins_out 1001,1002,3000,F000 on cycles 1-4 after reset release; halted=1 from cycle 5; imem_rd=0.
- ROM[5] = 6010 (BR), ROM[6] = 1111, ROM[0x10] = 2000. Drive branch_en=1, branch_val=0x0010 in the cycle 6010 is in the ALU -> 1111 never appears on ins_out; one NOP, then 2000 with pc_out=0x010.
- SYNC 8201 delivered, stall held 3 cycles -> ins_out = 8201 for all 3 cycles. After release: one NOP, then ROM[pc(8201)+1]; no skip, no duplicate.
- BOOT_RUN=0, fork_en=1, fork_pc=0x0040 in IDLE -> running=1 next cycle; ROM[0x40] on ins_out 2 cycles after fork. A second fork_en while RUN is ignored.
- pc starting at 0xFFE -> ins_out = ROM[0xFFE], ROM[0xFFF], ROM[0x000] consecutively.
- rst_n low mid-stall and mid-branch -> ins_out = NOP and state = reset state immediately; no in-flight word delivered after release.
